// File: rtl/rr_arbiter.sv
// Round-robin arbiter with registered one-hot grant, held until the owner drops its request.
// Optional forced release after MAX_HOLD grant cycles when ARB_TIMEOUT_EN is defined.
//
// state | meaning
// IDLE  | no grant active, scan req from ptr each edge
// GRANT | gnt_id owns the resource until it drops req (or is forced off)
module rr_arbiter #(
   parameter int N        = 4,
   parameter int ID_W     = 2,
   parameter int MAX_HOLD = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N-1:0]    req,
   output logic [N-1:0]    gnt,
   output logic [ID_W-1:0] gnt_id,
   output logic            gnt_valid,
   output logic            timeout
);

   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] GRANT = 1'b1;

   logic [0:0]      state;
   logic [ID_W-1:0] ptr;
   logic [ID_W-1:0] next_ptr;
   logic [ID_W-1:0] scan_base;
   logic [N-1:0]    rot;
   logic [ID_W-1:0] win_id;
   logic            win_found;
   logic [N-1:0]    win_onehot;
   logic            cur_req;
   logic            force_rel;
   logic            drop;

   assign next_ptr  = (gnt_id == ID_W'(N - 1)) ? '0 : gnt_id + 1'b1;
   assign scan_base = (state == GRANT) ? next_ptr : ptr;
   assign cur_req   = req[gnt_id];
   assign drop      = (state == GRANT) && (!cur_req || force_rel);
   assign gnt_valid = |gnt;

   // Rotate so bit 0 is the scan start; first set bit wins, wrap is modulo N.
   always_comb begin
      int sum;
      sum        = 0;
      win_found  = 1'b0;
      win_id     = '0;
      rot        = N'({req, req} >> scan_base);
      for (int k = 0; k < N; k++) begin
         if (!win_found && rot[k]) begin
            win_found = 1'b1;
            sum       = int'(scan_base) + k;
            if (sum >= N) sum = sum - N;
            win_id    = ID_W'(sum);
         end
      end
      win_onehot = N'(1) << win_id;
   end

`ifdef ARB_TIMEOUT_EN
   localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
   logic [7:0] hold_cnt;

   assign force_rel = cur_req && (hold_cnt == HOLD_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hold_cnt <= '0;
         timeout  <= 1'b0;
      end else begin
         timeout <= (state == GRANT) && force_rel;
         if ((state == IDLE) || drop) hold_cnt <= '0;
         else                         hold_cnt <= hold_cnt + 8'd1;
      end
   end
`else
   assign force_rel = 1'b0;
   assign timeout   = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         ptr    <= '0;
         gnt    <= '0;
         gnt_id <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (win_found) begin
                  gnt    <= win_onehot;
                  gnt_id <= win_id;
                  state  <= GRANT;
               end
            end
            GRANT: begin
               if (drop) begin
                  ptr <= next_ptr;
                  if (win_found) begin
                     gnt    <= win_onehot;
                     gnt_id <= win_id;
                  end else begin
                     gnt   <= '0;
                     state <= IDLE;
                  end
               end
            end
            default: begin
               state <= IDLE;
               gnt   <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rr_arbiter.sv
// Directed bench for rr_arbiter (N=4): per-cycle vector table plus async-reset,
// glitch and (when ARB_TIMEOUT_EN is defined) forced-release sequences.
module tb_rr_arbiter;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] req;
   logic [3:0] gnt;
   logic [1:0] gnt_id;
   logic       gnt_valid;
   logic       timeout;

   int checks = 0;
   int errors = 0;

   rr_arbiter #(.N(4), .ID_W(2), .MAX_HOLD(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .gnt       (gnt),
      .gnt_id    (gnt_id),
      .gnt_valid (gnt_valid),
      .timeout   (timeout)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       rst;
      logic [3:0] req;
      logic [3:0] gnt;
      logic [1:0] id;
      logic       valid;
   } vec_t;

   vec_t vecs[22];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   initial begin
      // reset, first grant, single requester
      vecs[0]  = '{1'b1, 4'b1111, 4'b0000, 2'd0, 1'b0};
      vecs[1]  = '{1'b0, 4'b1111, 4'b0001, 2'd0, 1'b1};
      vecs[2]  = '{1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0};
      vecs[3]  = '{1'b0, 4'b0100, 4'b0100, 2'd2, 1'b1};
      vecs[4]  = '{1'b0, 4'b0100, 4'b0100, 2'd2, 1'b1};
      vecs[5]  = '{1'b0, 4'b0000, 4'b0000, 2'd2, 1'b0};
      // skip and wrap from ptr=3
      vecs[6]  = '{1'b0, 4'b0011, 4'b0001, 2'd0, 1'b1};
      vecs[7]  = '{1'b0, 4'b0010, 4'b0010, 2'd1, 1'b1};
      vecs[8]  = '{1'b0, 4'b0000, 4'b0000, 2'd1, 1'b0};
      // rotation 0,1,2,3,0 without bubbles
      vecs[9]  = '{1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0};
      vecs[10] = '{1'b0, 4'b1111, 4'b0001, 2'd0, 1'b1};
      vecs[11] = '{1'b0, 4'b1111, 4'b0001, 2'd0, 1'b1};
      vecs[12] = '{1'b0, 4'b1110, 4'b0010, 2'd1, 1'b1};
      vecs[13] = '{1'b0, 4'b1111, 4'b0010, 2'd1, 1'b1};
      vecs[14] = '{1'b0, 4'b1101, 4'b0100, 2'd2, 1'b1};
      vecs[15] = '{1'b0, 4'b1111, 4'b0100, 2'd2, 1'b1};
      vecs[16] = '{1'b0, 4'b1011, 4'b1000, 2'd3, 1'b1};
      vecs[17] = '{1'b0, 4'b1111, 4'b1000, 2'd3, 1'b1};
      vecs[18] = '{1'b0, 4'b0111, 4'b0001, 2'd0, 1'b1};
      vecs[19] = '{1'b0, 4'b1111, 4'b0001, 2'd0, 1'b1};
      // hand over to requester 3 for the mid-grant reset
      vecs[20] = '{1'b0, 4'b1000, 4'b1000, 2'd3, 1'b1};
      vecs[21] = '{1'b0, 4'b1000, 4'b1000, 2'd3, 1'b1};

      rst = 1'b1;
      req = 4'b0000;
      #1;
      check("reset_async_gnt", 32'(gnt), 32'h0);

      for (int i = 0; i < 22; i++) begin
         @(negedge clk);
         rst = vecs[i].rst;
         req = vecs[i].req;
         @(posedge clk);
         #1;
         check($sformatf("vec%0d_gnt", i),   32'(gnt),       32'(vecs[i].gnt));
         check($sformatf("vec%0d_id", i),    32'(gnt_id),    32'(vecs[i].id));
         check($sformatf("vec%0d_valid", i), 32'(gnt_valid), 32'(vecs[i].valid));
`ifndef ARB_TIMEOUT_EN
         check($sformatf("vec%0d_timeout", i), 32'(timeout), 32'h0);
`endif
      end

      // reset mid-grant clears immediately, then restarts from ptr=0
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("midrst_gnt", 32'(gnt), 32'h0);
      check("midrst_valid", 32'(gnt_valid), 32'h0);
      req = 4'b1010;
      @(posedge clk);
      #1;
      check("midrst_held_gnt", 32'(gnt), 32'h0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("postrst_gnt", 32'(gnt), 32'b0010);
      check("postrst_id", 32'(gnt_id), 32'd1);

      // request pulse between edges is ignored
      @(negedge clk);
      req = 4'b0000;
      @(posedge clk);
      #1;
      check("release_gnt", 32'(gnt), 32'h0);
      @(negedge clk);
      #1 req = 4'b0001;
      #2 req = 4'b0000;
      @(posedge clk);
      #1;
      check("glitch_gnt", 32'(gnt), 32'h0);
      check("glitch_valid", 32'(gnt_valid), 32'h0);

`ifdef ARB_TIMEOUT_EN
      @(negedge clk);
      rst = 1'b1;
      #1 rst = 1'b0;
      req = 4'b0011;
      for (int c = 0; c < 8; c++) begin
         @(posedge clk);
         #1;
         check($sformatf("hold0_c%0d_gnt", c), 32'(gnt), 32'b0001);
         check($sformatf("hold0_c%0d_tmo", c), 32'(timeout), 32'h0);
      end
      @(posedge clk);
      #1;
      check("tmo_switch_gnt", 32'(gnt), 32'b0010);
      check("tmo_switch_pulse", 32'(timeout), 32'h1);
      @(posedge clk);
      #1;
      check("tmo_pulse_end", 32'(timeout), 32'h0);
      @(negedge clk);
      req = 4'b0001;
      for (int c = 0; c < 8; c++) begin
         @(posedge clk);
         #1;
         check($sformatf("solo_c%0d_gnt", c), 32'(gnt), 32'b0001);
         check($sformatf("solo_c%0d_tmo", c), 32'(timeout), 32'h0);
      end
      @(posedge clk);
      #1;
      check("solo_regrant_gnt", 32'(gnt), 32'b0001);
      check("solo_regrant_tmo", 32'(timeout), 32'h1);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
